// File: rtl/program_loader_if.sv
// Host beat stream between the instruction source and the program loader.
// The host drives valid/data/last; the loader answers with ready.
interface program_loader_if #(
    parameter int HOST_W = 16
) ();
    logic              host_valid;
    logic              host_ready;
    logic [HOST_W-1:0] host_data;
    logic              host_last;

    modport master (output host_valid, output host_data, output host_last, input host_ready);
    modport slave  (input host_valid, input host_data, input host_last, output host_ready);
endinterface

// File: rtl/program_loader.sv
// Assembles 16-bit host beats into 32-bit instructions, writes them to program memory
// and arms run_program. Optional beat checksum: define PROGRAM_LOADER_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | waiting for load_start (also the landing state after a protocol/checksum error)
// LOAD_HI | expecting the high half of the next instruction
// LOAD_LO | expecting the low half; the write is issued on its accept
// COMMIT  | final write in flight; pc_max latched here
// ARMED   | program loaded, run_program high until the next load_start
module program_loader #(
    parameter int ADDR_W = 10,
    parameter int HOST_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    program_loader_if.slave     host,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_wr_addr,
    output logic [2*HOST_W-1:0] mem_wr_data,
    output logic [31:0]         pc_max,
    output logic                run_program,
    output logic                busy,
    output logic                err_proto,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    input  logic [HOST_W-1:0]   csum_exp,
    output logic [HOST_W-1:0]   csum,
    output logic                err_csum,
`endif
    output logic                err_ovf
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_HI = 3'd1,
        LOAD_LO = 3'd2,
        COMMIT  = 3'd3,
        ARMED   = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W:0]   count;
    logic [HOST_W-1:0] hi_hold;
    logic              accept;

    assign host.host_ready = (state == LOAD_HI) || (state == LOAD_LO);
    assign busy            = (state == LOAD_HI) || (state == LOAD_LO) || (state == COMMIT);
    assign accept          = host.host_valid && host.host_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            hi_hold     <= '0;
            mem_we      <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            pc_max      <= '0;
            run_program <= 1'b0;
            err_proto   <= 1'b0;
            err_ovf     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum        <= '0;
            err_csum    <= 1'b0;
`endif
        end else begin
            mem_we <= 1'b0;
            // load_start overrides everything, including a beat accepted this same cycle
            if (load_start) begin
                state       <= LOAD_HI;
                count       <= '0;
                pc_max      <= '0;
                run_program <= 1'b0;
                err_proto   <= 1'b0;
                err_ovf     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                csum        <= '0;
                err_csum    <= 1'b0;
`endif
            end else begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (accept) begin
                    csum <= csum + host.host_data;
                end
`endif
                case (state)
                    IDLE: ;
                    LOAD_HI: begin
                        if (accept) begin
                            if (host.host_last) begin
                                err_proto <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                hi_hold <= host.host_data;
                                state   <= LOAD_LO;
                            end
                        end
                    end
                    LOAD_LO: begin
                        if (accept) begin
                            // count's top bit set means memory is already full
                            if (!count[ADDR_W]) begin
                                mem_we      <= 1'b1;
                                mem_wr_addr <= count[ADDR_W-1:0];
                                mem_wr_data <= {hi_hold, host.host_data};
                                count       <= count + 1'b1;
                            end else begin
                                err_ovf <= 1'b1;
                            end
                            state <= host.host_last ? COMMIT : LOAD_HI;
                        end
                    end
                    COMMIT: begin
                        pc_max <= 32'(count);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        if (csum != csum_exp) begin
                            err_csum <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            run_program <= 1'b1;
                            state       <= ARMED;
                        end
`else
                        run_program <= 1'b1;
                        state       <= ARMED;
`endif
                    end
                    ARMED: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader, built with a 4-entry memory so
// overflow is reachable with a short stream.
module tb_program_loader;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_start = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_wr_addr;
    logic [31:0]   mem_wr_data;
    logic [31:0]   pc_max;
    logic          run_program, busy, err_proto, err_ovf;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [15:0]   csum_exp = 16'h0000;
    logic [15:0]   csum;
    logic          err_csum;
    logic [15:0]   ref_sum = 16'h0000;
    bit            auto_csum = 1'b1;
`endif

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] wa [0:63];
    logic [31:0]   wd [0:63];
    int            wn = 0;

    program_loader_if #(.HOST_W(16)) host_if ();

    program_loader #(.ADDR_W(AW), .HOST_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .host        (host_if.slave),
        .mem_we      (mem_we),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .pc_max      (pc_max),
        .run_program (run_program),
        .busy        (busy),
        .err_proto   (err_proto),
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        .csum_exp    (csum_exp),
        .csum        (csum),
        .err_csum    (err_csum),
`endif
        .err_ovf     (err_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we && wn < 64) begin
            wa[wn] = mem_wr_addr;
            wd[wn] = mem_wr_data;
            wn++;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ref_sum = 16'h0000;
`endif
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Returns 1 ns after the accepting edge.
    task automatic send_beat(input logic [15:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        host_if.host_valid = 1'b1;
        host_if.host_data  = d;
        host_if.host_last  = last;
        while (host_if.host_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (host_if.host_ready !== 1'b1) begin
            $display("FAIL beat_wait ready=%b want 1 data=%h", host_if.host_ready, d);
            bad++;
            total++;
        end
        @(posedge clk);
        #1;
        host_if.host_valid = 1'b0;
        host_if.host_last  = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ref_sum = ref_sum + d;
        if (auto_csum && last) csum_exp = ref_sum;
`endif
    endtask

    task automatic test_reset();
        #1;
        if (host_if.host_ready !== 1'b0) begin $display("FAIL rst_ready got=%b want 0", host_if.host_ready); bad++; end total++;
        if (mem_we !== 1'b0)       begin $display("FAIL rst_we got=%b want 0", mem_we); bad++; end total++;
        if (pc_max !== 32'd0)      begin $display("FAIL rst_pc_max got=%0d want 0", pc_max); bad++; end total++;
        if (run_program !== 1'b0)  begin $display("FAIL rst_run got=%b want 0", run_program); bad++; end total++;
        if (busy !== 1'b0)         begin $display("FAIL rst_busy got=%b want 0", busy); bad++; end total++;
        if (err_proto !== 1'b0)    begin $display("FAIL rst_err_proto got=%b want 0", err_proto); bad++; end total++;
        if (err_ovf !== 1'b0)      begin $display("FAIL rst_err_ovf got=%b want 0", err_ovf); bad++; end total++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        if (host_if.host_ready !== 1'b0) begin $display("FAIL idle_ready got=%b want 0", host_if.host_ready); bad++; end total++;
    endtask

    task automatic test_load();
        int base;
        pulse_start();
        if (host_if.host_ready !== 1'b1) begin $display("FAIL load_ready got=%b want 1", host_if.host_ready); bad++; end total++;
        if (busy !== 1'b1) begin $display("FAIL load_busy got=%b want 1", busy); bad++; end total++;
        base = wn;
        send_beat(16'h4001, 1'b0);
        send_beat(16'h00AA, 1'b0);
        send_beat(16'h8002, 1'b0);
        send_beat(16'h0080, 1'b1);
        @(negedge clk);
        if (mem_we !== 1'b1)      begin $display("FAIL load_we_lat got=%b want 1", mem_we); bad++; end total++;
        if (run_program !== 1'b0) begin $display("FAIL load_run_early got=%b want 0", run_program); bad++; end total++;
        @(negedge clk);
        if (run_program !== 1'b1) begin $display("FAIL load_run got=%b want 1", run_program); bad++; end total++;
        if (pc_max !== 32'd2)     begin $display("FAIL load_pc_max got=%0d want 2", pc_max); bad++; end total++;
        if (busy !== 1'b0)        begin $display("FAIL load_armed_busy got=%b want 0", busy); bad++; end total++;
        if (wn - base !== 2)      begin $display("FAIL load_nwr got=%0d want 2", wn - base); bad++; end total++;
        if (wa[base] !== 2'd0 || wd[base] !== 32'h400100AA)
            begin $display("FAIL load_wr0 got=%0d:%h want 0:400100aa", wa[base], wd[base]); bad++; end total++;
        if (wa[base+1] !== 2'd1 || wd[base+1] !== 32'h80020080)
            begin $display("FAIL load_wr1 got=%0d:%h want 1:80020080", wa[base+1], wd[base+1]); bad++; end total++;
    endtask

    task automatic test_hold_armed();
        int base = wn;
        @(negedge clk);
        host_if.host_valid = 1'b1;
        host_if.host_data  = 16'h5555;
        host_if.host_last  = 1'b1;
        repeat (3) @(negedge clk);
        if (host_if.host_ready !== 1'b0) begin $display("FAIL hold_ready got=%b want 0", host_if.host_ready); bad++; end total++;
        host_if.host_valid = 1'b0;
        host_if.host_last  = 1'b0;
        @(negedge clk);
        if (wn - base !== 0)      begin $display("FAIL hold_nwr got=%0d want 0", wn - base); bad++; end total++;
        if (run_program !== 1'b1) begin $display("FAIL hold_run got=%b want 1", run_program); bad++; end total++;
    endtask

    task automatic test_rearm();
        pulse_start();
        if (run_program !== 1'b0) begin $display("FAIL rearm_run got=%b want 0", run_program); bad++; end total++;
        if (pc_max !== 32'd0)     begin $display("FAIL rearm_pc_max got=%0d want 0", pc_max); bad++; end total++;
        if (host_if.host_ready !== 1'b1) begin $display("FAIL rearm_ready got=%b want 1", host_if.host_ready); bad++; end total++;
    endtask

    task automatic test_proto();
        int base = wn;
        send_beat(16'h1234, 1'b1);
        @(negedge clk);
        if (err_proto !== 1'b1)   begin $display("FAIL proto_err got=%b want 1", err_proto); bad++; end total++;
        if (busy !== 1'b0)        begin $display("FAIL proto_idle_busy got=%b want 0", busy); bad++; end total++;
        if (host_if.host_ready !== 1'b0) begin $display("FAIL proto_ready got=%b want 0", host_if.host_ready); bad++; end total++;
        @(negedge clk);
        if (run_program !== 1'b0) begin $display("FAIL proto_run got=%b want 0", run_program); bad++; end total++;
        if (pc_max !== 32'd0)     begin $display("FAIL proto_pc_max got=%0d want 0", pc_max); bad++; end total++;
        if (wn - base !== 0)      begin $display("FAIL proto_nwr got=%0d want 0", wn - base); bad++; end total++;
    endtask

    task automatic test_overflow();
        int base;
        pulse_start();
        if (err_proto !== 1'b0) begin $display("FAIL ovf_proto_clr got=%b want 0", err_proto); bad++; end total++;
        base = wn;
        for (int i = 0; i < 5; i++) begin
            send_beat(16'h1000 + 16'(i), 1'b0);
            send_beat(16'h2000 + 16'(i), i == 4);
        end
        @(negedge clk);
        @(negedge clk);
        if (err_ovf !== 1'b1)     begin $display("FAIL ovf_err got=%b want 1", err_ovf); bad++; end total++;
        if (pc_max !== 32'd4)     begin $display("FAIL ovf_pc_max got=%0d want 4", pc_max); bad++; end total++;
        if (run_program !== 1'b1) begin $display("FAIL ovf_run got=%b want 1", run_program); bad++; end total++;
        if (wn - base !== 4)      begin $display("FAIL ovf_nwr got=%0d want 4", wn - base); bad++; end total++;
        for (int i = 0; i < 4; i++) begin
            if (wa[base+i] !== 2'(i) || wd[base+i] !== {16'h1000 + 16'(i), 16'h2000 + 16'(i)}) begin
                $display("FAIL ovf_wr%0d got=%0d:%h want %0d:%h", i, wa[base+i], wd[base+i], i,
                         {16'h1000 + 16'(i), 16'h2000 + 16'(i)});
                bad++;
            end
            total++;
        end
        pulse_start();
        if (err_ovf !== 1'b0) begin $display("FAIL ovf_clr got=%b want 0", err_ovf); bad++; end total++;
    endtask

    task automatic test_abort();
        int base = wn;
        send_beat(16'hAAAA, 1'b0);
        @(negedge clk);
        host_if.host_valid = 1'b1;
        host_if.host_data  = 16'hBBBB;
        host_if.host_last  = 1'b1;
        load_start = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ref_sum = 16'h0000;
`endif
        @(negedge clk);
        load_start = 1'b0;
        host_if.host_valid = 1'b0;
        host_if.host_last  = 1'b0;
        if (mem_we !== 1'b0) begin $display("FAIL abort_we got=%b want 0", mem_we); bad++; end total++;
        if (host_if.host_ready !== 1'b1) begin $display("FAIL abort_ready got=%b want 1", host_if.host_ready); bad++; end total++;
        @(negedge clk);
        if (wn - base !== 0) begin $display("FAIL abort_nwr got=%0d want 0", wn - base); bad++; end total++;
        send_beat(16'h0001, 1'b0);
        send_beat(16'h0002, 1'b1);
        @(negedge clk);
        @(negedge clk);
        if (pc_max !== 32'd1 || run_program !== 1'b1)
            begin $display("FAIL abort_min got=%0d/%b want 1/1", pc_max, run_program); bad++; end total++;
        if (wn - base !== 1 || wa[base] !== 2'd0 || wd[base] !== 32'h00010002)
            begin $display("FAIL abort_wr got=%0d %0d:%h want 1 0:00010002", wn - base, wa[base], wd[base]); bad++; end total++;
    endtask

    task automatic test_rst_mid();
        int base;
        pulse_start();
        send_beat(16'hCAFE, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        if (busy !== 1'b0 || host_if.host_ready !== 1'b0)
            begin $display("FAIL rstmid_busy got=%b/%b want 0/0", busy, host_if.host_ready); bad++; end total++;
        if (pc_max !== 32'd0 || run_program !== 1'b0 || mem_we !== 1'b0)
            begin $display("FAIL rstmid_outs got=%0d/%b/%b want 0/0/0", pc_max, run_program, mem_we); bad++; end total++;
        @(negedge clk);
        rst = 1'b0;
        base = wn;
        pulse_start();
        send_beat(16'h0C0C, 1'b0);
        send_beat(16'h0D0D, 1'b1);
        @(negedge clk);
        @(negedge clk);
        if (wn - base !== 1 || wa[base] !== 2'd0 || wd[base] !== 32'h0C0C0D0D)
            begin $display("FAIL rstmid_wr got=%0d %0d:%h want 1 0:0c0c0d0d", wn - base, wa[base], wd[base]); bad++; end total++;
        if (pc_max !== 32'd1 || run_program !== 1'b1)
            begin $display("FAIL rstmid_arm got=%0d/%b want 1/1", pc_max, run_program); bad++; end total++;
    endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        auto_csum = 1'b0;
        pulse_start();
        csum_exp = 16'h0001;
        send_beat(16'hFFFF, 1'b0);
        send_beat(16'h0002, 1'b1);
        @(negedge clk);
        @(negedge clk);
        if (csum !== 16'h0001) begin $display("FAIL csum_val got=%h want 0001", csum); bad++; end total++;
        if (run_program !== 1'b1 || err_csum !== 1'b0)
            begin $display("FAIL csum_ok got=%b/%b want 1/0", run_program, err_csum); bad++; end total++;
        pulse_start();
        csum_exp = 16'h0000;
        send_beat(16'hFFFF, 1'b0);
        send_beat(16'h0002, 1'b1);
        @(negedge clk);
        @(negedge clk);
        if (err_csum !== 1'b1 || run_program !== 1'b0)
            begin $display("FAIL csum_bad got=%b/%b want 1/0", err_csum, run_program); bad++; end total++;
        if (pc_max !== 32'd1 || busy !== 1'b0)
            begin $display("FAIL csum_bad_state got=%0d/%b want 1/0", pc_max, busy); bad++; end total++;
        auto_csum = 1'b1;
    endtask
`endif

    initial begin
        host_if.host_valid = 1'b0;
        host_if.host_data  = 16'h0000;
        host_if.host_last  = 1'b0;
        test_reset();
        test_load();
        test_hold_armed();
        test_rearm();
        test_proto();
        test_overflow();
        test_abort();
        test_rst_mid();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Upstream stage of the instruction-program driver.
- Accepts a 16-bit host beat stream with valid/ready and assembles 32-bit instructions (high half first).
- Writes each assembled instruction into program memory at consecutive addresses from 0.
- On completion, publishes pc_max (the instruction count) and raises run_program so the driver can execute the loaded program.

Parameters:
ADDR_W, 10, program memory address width; depth = 2**ADDR_W instructions
HOST_W, 16, host beat width; fixed at half of the 32-bit instruction

Ports:
clk  input  1  clock
rst  input  1  reset
load_start  input  1  1-cycle pulse: begin new load, clear count/flags, drop run_program
host_valid  input  1  host beat valid
host_ready  output  1  loader accepts beat
host_data  input  16  beat payload
host_last  input  1  final beat of program; legal only on a low-half beat
mem_we  output  1  program memory write strobe, 1 cycle per instruction
mem_wr_addr  output  ADDR_W  program memory write address
mem_wr_data  output  32  assembled instruction {hi,lo}
pc_max  output  32  number of instructions loaded (zero-extended)
run_program  output  1  level: program loaded and armed
busy  output  1  high in LOAD_HI/LOAD_LO/COMMIT
err_proto  output  1  sticky: host_last seen on a high-half beat
err_ovf  output  1  sticky: more than 2**ADDR_W instructions offered

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values: all outputs 0; state IDLE; count 0; hi_hold 0.
- A beat is accepted when host_valid & host_ready on a rising clk edge.
- host_ready = 1 only in LOAD_HI and LOAD_LO; 0 in IDLE, COMMIT, ARMED.
- States and transitions:
  - IDLE: wait for load_start -> LOAD_HI.
  - LOAD_HI: on accept, hi_hold <= host_data -> LOAD_LO.
    - If host_last is set on this beat: err_proto <= 1, partial word discarded, nothing written -> IDLE. pc_max and run_program stay 0.
  - LOAD_LO: on accept, register mem_wr_data <= {hi_hold, host_data} and mem_wr_addr <= count.
    - mem_we is asserted for 1 cycle, in the cycle after the accept, only if count < 2**ADDR_W.
    - Otherwise set err_ovf and do not write.
    - count saturates at 2**ADDR_W (count is ADDR_W+1 bits wide).
    - Move to COMMIT if host_last, else LOAD_HI.
  - COMMIT: the final write occurs in this cycle. pc_max <= final count (saturated) -> ARMED next cycle.
  - ARMED: run_program = 1 (registered). Stay until load_start.
- Latency: accept of the final low beat -> mem_we 1 cycle later -> run_program 2 cycles later.
- load_start in any state:
  - resets count, err_proto, err_ovf, pc_max and run_program (cleared the next cycle);
  - aborts any partial word;
  - goes to LOAD_HI.
  - No mem_we is issued for the aborted partial word.
  - If a low-half beat is accepted in the same cycle as load_start, that beat is dropped and load_start wins.
- host_valid with host_ready low: the beat is not consumed. The host must hold it.
- Empty program: not expressible, because host_last needs a low beat. The minimum program is 1 instruction, giving pc_max = 1.
- Reset mid-load: everything returns to the reset values immediately (asynchronous). Memory contents are untouched.

Optional Feature:
Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Enabled:
  - Extra input csum_exp[15:0] and output csum[15:0].
  - csum is the running 16-bit modular sum of every accepted beat, cleared by load_start and by rst.
  - In COMMIT, if csum != csum_exp: err_csum (extra sticky output) <= 1, go to IDLE, run_program stays 0, pc_max is still updated.
- Disabled: no csum/err_csum ports; COMMIT always goes to ARMED.

Test Plan:
- Reset, then load_start; beats 0x4001,0x00AA,0x8002,0x0080 with last on the 4th beat -> mem_we at addr 0 data 0x400100AA, then addr 1 data 0x80020080; pc_max=2; run_program=1 two cycles after the last accept.
- host_last on a high beat (1st beat 0x1234, last=1) -> err_proto=1, no mem_we, state IDLE, run_program=0.
- ADDR_W=2, stream 5 instructions -> 4 writes at addr 0..3, err_ovf=1, pc_max=4, run_program=1.
- In ARMED with pc_max=2, pulse load_start -> run_program=0 next cycle, pc_max=0, host_ready=1.
- Mid-load: assert rst between hi and lo beats -> all outputs 0 asynchronously; after release, a fresh load of 1 instruction writes addr 0.
- With PROGRAM_LOADER_CHECKSUM_EN: beats 0xFFFF,0x0002 and csum_exp=0x0001 -> ARMED. Same beats with csum_exp=0x0000 -> err_csum=1, run_program=0.
